unique_selector: RTL and testbench
==================================

UNIQUE_SELECTOR -- requirements
Module: unique_selector

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter NUM_HOLES, default 16, SHALL set the number of selectable holes; the legal range is 8..16.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, SHALL set the LFSR reset value; a zero value SHALL be replaced by 16'h0001.
REQ-004 The block SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req  in  1  request a new unique hole number; level input
- clear  in  1  start a new round by emptying the used-mask
- selected_number  out  4  last committed hole number; registered
- done  out  1  one-cycle pulse, selected_number valid
- all_selected  out  1  level; all NUM_HOLES holes used this round
- used_mask  out  16  bit i set means hole i is used; bits >= NUM_HOLES read 0

Function
REQ-005 A 16-bit Galois LFSR SHALL free-run every cycle: lfsr <= {1'b0,lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0).
REQ-006 The FSM SHALL have four states: IDLE, DRAW, PROBE, COMMIT.
REQ-007 IDLE->DRAW SHALL occur on an edge where req=1, clear=0, all_selected=0 and done=0; req SHALL NOT be sampled in the cycle done is high.
REQ-008 DRAW SHALL latch the candidate and go to PROBE.
- candidate = lfsr[3:0] when lfsr[3:0] < NUM_HOLES
- candidate = lfsr[3:0] - NUM_HOLES otherwise
REQ-009 In PROBE, a free candidate SHALL go to COMMIT.
- A used candidate SHALL advance to (candidate+1) mod NUM_HOLES and stay in PROBE, one probe per cycle.
- PROBE SHALL last at most NUM_HOLES cycles.
REQ-010 The COMMIT edge SHALL set used_mask[candidate], load selected_number, drive done=1 for exactly one cycle, and return to IDLE.
REQ-011 Latency: if the req-sampling edge is edge 0, done SHALL be high in the cycle after edge 2+P, where P is the number of used slots probed (0..NUM_HOLES-1).
REQ-012 all_selected SHALL be registered, equal to &used_mask[NUM_HOLES-1:0], and rise in the same cycle as the final done.
REQ-013 req while all_selected=1 SHALL be ignored: no done, and no state change.
REQ-014 clear SHALL zero used_mask and all_selected on the next edge, from any state. An in-progress draw SHALL be aborted to IDLE without done. The LFSR and selected_number SHALL be unaffected.
REQ-015 When clear and req are both high on the same edge, clear SHALL win and that req SHALL be dropped.
REQ-016 req deasserted mid-draw SHALL NOT abort the draw; done still pulses.
REQ-017 Within one round, selected values SHALL never repeat, and every value SHALL be < NUM_HOLES.

Reset
REQ-018 rst SHALL act synchronously and override clear and req.
REQ-019 On reset: state=IDLE, used_mask=0, selected_number=0, done=0, all_selected=0, lfsr=LFSR_SEED (or 1 if the seed is 0).
REQ-020 A reset mid-draw SHALL produce no done pulse.

Configuration
REQ-021 With macro UNIQUE_SELECTOR_ENTROPY_EN defined, the block SHALL add input entropy_in (1 bit), XORed into lfsr[15] of the next LFSR value every cycle.
REQ-022 Without UNIQUE_SELECTOR_ENTROPY_EN, port entropy_in SHALL NOT exist and the sequence SHALL be fully deterministic from LFSR_SEED.

Verification
REQ-023 Default parameters, reset, then 16 req handshakes -> 16 done pulses; the values form a permutation of 0..15; all_selected=1 with the 16th done; used_mask=16'hFFFF.
REQ-024 After REQ-023, hold req=1 for 40 cycles -> no done, and selected_number unchanged.
REQ-025 First req after reset with an empty mask -> done high in the cycle after edge 2; selected_number matches the REQ-005 reference model.
REQ-026 Pulse clear during PROBE with 15 holes used -> no done; used_mask=0 and all_selected=0 on the next cycle; the next req yields a value in 0..15.
REQ-027 NUM_HOLES=10, 10 req handshakes -> all values in 0..9 and unique; used_mask=16'h03FF; all_selected=1.
REQ-028 clear and req high on the same edge in IDLE -> no draw starts and used_mask=0; with UNIQUE_SELECTOR_ENTROPY_EN and entropy_in=0 constant, the sequence is identical to the macro-off build.

Source files
------------

// File: rtl/unique_selector_if.sv
// unique_selector_if
//   Groups the request/result signals of unique_selector.
//   master : the requester. It drives req and clear, and observes the results.
//   slave  : the selector. It samples req and clear, and drives the results.
//   Signals:
//     req             level request for a new unique hole number
//     clear           start a new round (empties the used-mask)
//     selected_number last committed hole number
//     done            one-cycle pulse; selected_number is valid
//     all_selected    level; every hole has been used this round
//     used_mask       bit i set means hole i is used
interface unique_selector_if;
  logic        req;
  logic        clear;
  logic [3:0]  selected_number;
  logic        done;
  logic        all_selected;
  logic [15:0] used_mask;

  modport master (
    output req, clear,
    input  selected_number, done, all_selected, used_mask
  );

  modport slave (
    input  req, clear,
    output selected_number, done, all_selected, used_mask
  );
endinterface

// File: rtl/unique_selector.sv
// unique_selector
//   Draws hole numbers in 0..NUM_HOLES-1 without repetition within a round.
//   A free-running 16-bit Galois LFSR picks a starting candidate. A linear
//   probe then walks to the next unused hole, one hole per cycle.
//   Parameters:
//     NUM_HOLES  number of selectable holes (8..16)
//     LFSR_SEED  LFSR reset value; a zero seed is replaced by 16'h0001
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous active-high reset
//     entropy_in  (only with UNIQUE_SELECTOR_ENTROPY_EN) XORed into lfsr[15]
//     bus         unique_selector_if.slave: req, clear in; selected_number,
//                 done, all_selected, used_mask out (all registered)
//   Optional feature macro: UNIQUE_SELECTOR_ENTROPY_EN
module unique_selector #(
  parameter int          NUM_HOLES = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clk,
  input logic rst,
`ifdef UNIQUE_SELECTOR_ENTROPY_EN
  input logic entropy_in,
`endif
  unique_selector_if.slave bus
);

  // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [4:0]  HOLES     = 5'(NUM_HOLES);
  localparam logic [15:0] HOLE_MASK = 16'((32'h1 << NUM_HOLES) - 32'h1);

  typedef enum logic [1:0] {IDLE, DRAW, PROBE, COMMIT} state_t;

  state_t      state_reg;
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic [3:0]  cand_reg;
  logic [15:0] mask_reg;
  logic [3:0]  sel_reg;
  logic        done_reg;
  logic        all_reg;

  logic [3:0]  draw_cand;
  logic [4:0]  cand_inc;
  logic [3:0]  probe_next;
  logic [15:0] cand_onehot;
  logic [15:0] commit_mask;
  logic        cand_used;

  // Galois LFSR step. With the entropy feature enabled, an external bit
  // perturbs the top bit.
  always_comb begin
    lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
`ifdef UNIQUE_SELECTOR_ENTROPY_EN
    lfsr_next[15] = lfsr_next[15] ^ entropy_in;
`endif
  end

  // The low nibble is at most 15. NUM_HOLES is at least 8, so a single
  // subtraction folds any out-of-range nibble into range.
  assign draw_cand = ({1'b0, lfsr_reg[3:0]} < HOLES) ?
                     lfsr_reg[3:0] : 4'({1'b0, lfsr_reg[3:0]} - HOLES);

  // Wrap the probe pointer at NUM_HOLES rather than at 16.
  assign cand_inc   = {1'b0, cand_reg} + 5'd1;
  assign probe_next = (cand_inc == HOLES) ? 4'd0 : cand_inc[3:0];

  // One-hot decode of the candidate. It is used both to test the mask and
  // to set the mask bit.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi = gi + 1) begin : g_onehot
      assign cand_onehot[gi] = (cand_reg == 4'(gi));
    end
  endgenerate

  assign cand_used   = |(cand_onehot & mask_reg);
  assign commit_mask = mask_reg | cand_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      lfsr_reg  <= SEED_EFF;
      cand_reg  <= 4'd0;
      mask_reg  <= 16'h0000;
      sel_reg   <= 4'd0;
      done_reg  <= 1'b0;
      all_reg   <= 1'b0;
    end else begin
      lfsr_reg <= lfsr_next;
      done_reg <= 1'b0;
      if (bus.clear) begin
        // clear takes priority over everything except reset. It aborts any
        // draw in progress and drops a coincident req.
        state_reg <= IDLE;
        mask_reg  <= 16'h0000;
        all_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.req && !all_reg && !done_reg) begin
              state_reg <= DRAW;
            end
          end
          DRAW: begin
            cand_reg  <= draw_cand;
            state_reg <= PROBE;
          end
          PROBE: begin
            // At least one hole is free whenever a draw starts, so this
            // walk ends within NUM_HOLES cycles.
            if (cand_used) begin
              cand_reg <= probe_next;
            end else begin
              mask_reg  <= commit_mask;
              sel_reg   <= cand_reg;
              done_reg  <= 1'b1;
              all_reg   <= ((commit_mask & HOLE_MASK) == HOLE_MASK);
              state_reg <= COMMIT;
            end
          end
          COMMIT: begin
            // This cycle carries the done pulse. req is not sampled here.
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.selected_number = sel_reg;
  assign bus.done            = done_reg;
  assign bus.all_selected    = all_reg;
  assign bus.used_mask       = mask_reg & HOLE_MASK;

endmodule

// File: tb/tb_unique_selector.sv
// tb_unique_selector
//   Scoreboard bench for unique_selector. Two instances are used:
//     dut_a  NUM_HOLES=16, seed 16'hACE1
//     dut_b  NUM_HOLES=10, seed 0 (replaced by 1)
//   When a draw is issued, the expected hole, done cycle, mask and
//   all_selected value are pushed into a queue. The expected hole comes
//   from the LFSR formula, modulo NUM_HOLES, and a search for the next free
//   hole. Per-instance monitors pop the queue and compare whenever done
//   rises.
module tb_unique_selector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unique_selector_if bus_a();
  unique_selector_if bus_b();

`ifdef UNIQUE_SELECTOR_ENTROPY_EN
  logic entropy_a = 1'b0;
  logic entropy_b = 1'b0;
`endif

  unique_selector #(.NUM_HOLES(16), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk),
    .rst(rst),
`ifdef UNIQUE_SELECTOR_ENTROPY_EN
    .entropy_in(entropy_a),
`endif
    .bus(bus_a.slave)
  );

  unique_selector #(.NUM_HOLES(10), .LFSR_SEED(16'h0000)) dut_b (
    .clk(clk),
    .rst(rst),
`ifdef UNIQUE_SELECTOR_ENTROPY_EN
    .entropy_in(entropy_b),
`endif
    .bus(bus_b.slave)
  );

  typedef struct {
    int          value;
    int          cyc;
    logic [15:0] mask;
    logic        all;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] m_lfsr [2];
  logic [15:0] m_used [2];
  logic [15:0] seen_vals [2];
  int          last_val [2];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int holes(input int inst);
    return (inst == 0) ? 16 : 10;
  endfunction

  function automatic logic [15:0] full_mask(input int n);
    return 16'((32'h1 << n) - 32'h1);
  endfunction

  // Cycle counter and reference LFSRs, both in step with the clock.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_lfsr[0] <= 16'hACE1;
      m_lfsr[1] <= 16'h0001;
    end else begin
      m_lfsr[0] <= lfsr_step(m_lfsr[0]);
      m_lfsr[1] <= lfsr_step(m_lfsr[1]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_done(input int inst, input logic [3:0] sel,
                            input logic [15:0] mask, input logic all);
    exp_t e;
    if ((inst == 0 && q_a.size() == 0) || (inst == 1 && q_b.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_done inst=%0d: got done=1 sel=%0d expected no done", inst, sel);
      return;
    end
    e = (inst == 0) ? q_a.pop_front() : q_b.pop_front();
    chk($sformatf("value[%0d]", inst), 32'(sel), 32'(e.value));
    chk($sformatf("done_cycle[%0d]", inst), 32'(cyc), 32'(e.cyc));
    chk($sformatf("used_mask[%0d]", inst), 32'(mask), 32'(e.mask));
    chk($sformatf("all_selected[%0d]", inst), 32'(all), 32'(e.all));
    chk($sformatf("in_range[%0d]", inst), 32'(int'(sel) < holes(inst)), 32'd1);
    chk($sformatf("unique[%0d]", inst), 32'(seen_vals[inst][sel]), 32'd0);
    seen_vals[inst][sel] = 1'b1;
  endtask

  always @(negedge clk) if (bus_a.done) check_done(0, bus_a.selected_number, bus_a.used_mask, bus_a.all_selected);
  always @(negedge clk) if (bus_b.done) check_done(1, bus_b.selected_number, bus_b.used_mask, bus_b.all_selected);

  task automatic set_req(input int inst, input logic v);
    if (inst == 0) bus_a.req = v; else bus_b.req = v;
  endtask

  task automatic set_clear(input int inst, input logic v);
    if (inst == 0) bus_a.clear = v; else bus_b.clear = v;
  endtask

  function automatic logic get_done(input int inst);
    return (inst == 0) ? bus_a.done : bus_b.done;
  endfunction

  // Called at a negedge while the DUT is idle.
  task automatic do_draw(input int inst, input bit drop_early);
    logic [15:0] nxt;
    logic [3:0]  raw;
    int          n, c, p;
    exp_t        e;
    bit          seen;
    n   = holes(inst);
    nxt = lfsr_step(m_lfsr[inst]);   // LFSR value the DRAW state will see
    raw = nxt[3:0];
    c   = int'(raw) % n;
    p   = 0;
    while (m_used[inst][c]) begin
      c = (c + 1) % n;
      p++;
    end
    m_used[inst][c] = 1'b1;
    e.value = c;
    e.cyc   = cyc + 3 + p;
    e.mask  = m_used[inst];
    e.all   = (m_used[inst] == full_mask(n));
    last_val[inst] = c;
    if (inst == 0) q_a.push_back(e); else q_b.push_back(e);
    set_req(inst, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (drop_early) set_req(inst, 1'b0);
      seen = get_done(inst);
    end
    set_req(inst, 1'b0);
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout inst=%0d: got no done expected done for %0d", inst, c);
    end
    @(negedge clk);
  endtask

  task automatic do_clear(input int inst);
    set_clear(inst, 1'b1);
    @(negedge clk);
    set_clear(inst, 1'b0);
    m_used[inst]    = 16'h0000;
    seen_vals[inst] = 16'h0000;
    chk($sformatf("clear_mask[%0d]", inst), 32'(inst == 0 ? bus_a.used_mask : bus_b.used_mask), 32'd0);
    chk($sformatf("clear_all[%0d]", inst), 32'(inst == 0 ? bus_a.all_selected : bus_b.all_selected), 32'd0);
  endtask

  task automatic hold_req(input int inst, input int cycles);
    set_req(inst, 1'b1);
    repeat (cycles) @(negedge clk);
    set_req(inst, 1'b0);
    chk($sformatf("hold_sel[%0d]", inst),
        32'(inst == 0 ? bus_a.selected_number : bus_b.selected_number), 32'(last_val[inst]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.req = 1'b0; bus_a.clear = 1'b0;
    bus_b.req = 1'b0; bus_b.clear = 1'b0;
    m_used[0] = 16'h0; m_used[1] = 16'h0;
    seen_vals[0] = 16'h0; seen_vals[1] = 16'h0;
    last_val[0] = 0; last_val[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(bus_a.selected_number), 32'd0);
    chk("rst_done", 32'(bus_a.done), 32'd0);
    chk("rst_all", 32'(bus_a.all_selected), 32'd0);
    chk("rst_mask", 32'(bus_a.used_mask), 32'd0);
    chk("rst_mask_b", 32'(bus_b.used_mask), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full round on the 16-hole instance. The first draw also checks
    // latency from an empty mask.
    for (int i = 0; i < 16; i++) do_draw(0, 1'b0);
    chk("perm_a", 32'(seen_vals[0]), 32'h0000FFFF);
    chk("full_mask_a", 32'(bus_a.used_mask), 32'h0000FFFF);
    chk("full_all_a", 32'(bus_a.all_selected), 32'd1);
    hold_req(0, 40);

    // Abort a draw in PROBE with 15 holes used.
    do_clear(0);
    for (int i = 0; i < 15; i++) do_draw(0, 1'b0);
    bus_a.req = 1'b1;
    repeat (2) @(negedge clk);
    bus_a.req = 1'b0;
    bus_a.clear = 1'b1;
    @(negedge clk);
    bus_a.clear = 1'b0;
    m_used[0] = 16'h0;
    seen_vals[0] = 16'h0;
    chk("abort_mask", 32'(bus_a.used_mask), 32'd0);
    chk("abort_all", 32'(bus_a.all_selected), 32'd0);
    chk("abort_done", 32'(bus_a.done), 32'd0);
    repeat (5) @(negedge clk);
    do_draw(0, 1'b0);

    // clear and req on the same idle edge: clear wins, no draw starts.
    do_draw(0, 1'b0);
    bus_a.req = 1'b1;
    bus_a.clear = 1'b1;
    @(negedge clk);
    bus_a.req = 1'b0;
    bus_a.clear = 1'b0;
    m_used[0] = 16'h0;
    seen_vals[0] = 16'h0;
    chk("clr_req_mask", 32'(bus_a.used_mask), 32'd0);
    repeat (6) @(negedge clk);

    // Randomised draws, gaps, early req drops and clears.
    for (int i = 0; i < 60; i++) begin
      if (m_used[0] == 16'hFFFF || $urandom_range(0, 11) == 0) begin
        do_clear(0);
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_draw(0, 1'($urandom_range(0, 1)));
      end
    end

    // 10-hole instance with a zero seed.
    for (int i = 0; i < 10; i++) do_draw(1, 1'b0);
    chk("perm_b", 32'(seen_vals[1]), 32'h000003FF);
    chk("full_mask_b", 32'(bus_b.used_mask), 32'h000003FF);
    chk("full_all_b", 32'(bus_b.all_selected), 32'd1);
    hold_req(1, 12);

    // Reset during a draw: no done, and everything returns to its reset
    // value.
    do_clear(0);
    bus_a.req = 1'b1;
    repeat (2) @(negedge clk);
    bus_a.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_used[0] = 16'h0; m_used[1] = 16'h0;
    seen_vals[0] = 16'h0; seen_vals[1] = 16'h0;
    last_val[0] = 0; last_val[1] = 0;
    chk("mid_rst_done", 32'(bus_a.done), 32'd0);
    chk("mid_rst_sel", 32'(bus_a.selected_number), 32'd0);
    chk("mid_rst_mask_b", 32'(bus_b.used_mask), 32'd0);
    repeat (4) @(negedge clk);
    do_draw(0, 1'b0);
    do_draw(1, 1'b0);
    repeat (4) @(negedge clk);

    if (q_a.size() != 0 || q_b.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expect: got %0d/%0d pending expected 0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
